// File: rtl/tank_pkg.sv
// Shared definitions for the object line scheduler.
// Covers the OAM entry field layout, the default object size and the scan FSM encoding.
package tank_pkg;

  localparam int ENTRY_W = 32;
  localparam int TILE_PX = 32;

  localparam int TYPE_HI = 30;
  localparam int TYPE_LO = 29;
  localparam int EN_BIT  = 28;
  localparam int POSX_HI = 27;
  localparam int POSX_LO = 18;
  localparam int POSY_HI = 17;
  localparam int POSY_LO = 8;
  localparam int DIR_HI  = 7;
  localparam int DIR_LO  = 6;
  localparam int ROW_HI  = 5;
  localparam int ROW_LO  = 3;
  localparam int COL_HI  = 2;
  localparam int COL_LO  = 0;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_IDLE  = 2'd0;
  localparam scan_state_t ST_SCAN  = 2'd1;
  localparam scan_state_t ST_DRAIN = 2'd2;
  localparam scan_state_t ST_SWAP  = 2'd3;

  function automatic logic entry_enable(input logic [ENTRY_W-1:0] e);
    return e[EN_BIT];
  endfunction

  // Positions are widened to 11 bits so base + size never wraps at 1023.
  function automatic logic [10:0] entry_pos_x(input logic [ENTRY_W-1:0] e);
    return {1'b0, e[POSX_HI:POSX_LO]};
  endfunction

  function automatic logic [10:0] entry_pos_y(input logic [ENTRY_W-1:0] e);
    return {1'b0, e[POSY_HI:POSY_LO]};
  endfunction

  function automatic logic span_hit(input logic [10:0] p, input logic [10:0] base,
                                    input logic [10:0] size);
    return (p >= base) && (p < base + size);
  endfunction

endpackage

// File: rtl/oam_line_scheduler_if.sv
// Pixel-counter, OAM-read and object-output bundle for the line scheduler.
interface oam_line_scheduler_if #(
  parameter int OAM_DEPTH = 8
) ();
  localparam int AW = (OAM_DEPTH > 1) ? $clog2(OAM_DEPTH) : 1;

  logic [9:0]    x;
  logic [9:0]    y;
  logic          video_on;
  logic [AW-1:0] oam_addr;
  logic [31:0]   oam_rdata;
  logic [31:0]   obj_data;
  logic          obj_valid;
  logic          overflow;
  logic          scan_busy;

  modport master (
    output x, y, video_on, oam_rdata,
    input  oam_addr, obj_data, obj_valid, overflow, scan_busy
  );

  modport slave (
    input  x, y, video_on, oam_rdata,
    output oam_addr, obj_data, obj_valid, overflow, scan_busy
  );
endinterface

// File: rtl/oam_slot_select.sv
// Priority selector: picks the lowest populated slot whose span covers the pixel x.
module oam_slot_select
  import tank_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int TILE  = TILE_PX,
  localparam int CW   = $clog2(SLOTS + 1),
  localparam int IW   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [10:0]   slot_x [SLOTS],
  input  logic [CW-1:0] slot_count,
  input  logic [9:0]    px,
  output logic [IW-1:0] sel_idx,
  output logic          sel_hit
);

  localparam logic [10:0] TILE_W = 11'(TILE);

  // Walk from the top down so the lowest covering slot is the last one written.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((CW'(i) < slot_count) && span_hit({1'b0, px}, slot_x[i], TILE_W)) begin
        sel_idx = IW'(i);
        sel_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oam_line_scheduler.sv
// Scans OAM during horizontal blanking for objects on the next line, then
// serves the highest-priority covering object for each pixel of that line.
module oam_line_scheduler
  import tank_pkg::*;
#(
  parameter int OAM_DEPTH    = 8,
  parameter int SLOTS        = 4,
  parameter int TILE         = TILE_PX,
  parameter int H_SCAN_START = 640,
  parameter int V_LINES      = 525
) (
  input logic               clk,
  input logic               rst,
  oam_line_scheduler_if.slave bus
);

  localparam int AW = (OAM_DEPTH > 1) ? $clog2(OAM_DEPTH) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(OAM_DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [CW-1:0] SLOT_MAX  = CW'(SLOTS);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [10:0]   TILE_W    = 11'(TILE);
  localparam logic [9:0]    TRIGGER_X = 10'(H_SCAN_START);
  localparam logic [9:0]    LAST_LINE = 10'(V_LINES - 1);

  scan_state_t   state;
  logic [AW-1:0] addr;

  logic [31:0]   pend_slots [SLOTS];
  logic [CW-1:0] pend_count;
  logic          pend_ovf;

  logic [31:0]   act_slots [SLOTS];
  logic [10:0]   act_x [SLOTS];
  logic [CW-1:0] act_count;
  logic          act_ovf;

  logic          trigger;
  logic          eval_now;
  logic          entry_hit;
  logic [10:0]   next_line;

  logic [IW-1:0] sel_idx;
  logic          sel_hit;
  logic [31:0]   obj_data_q;
  logic          obj_valid_q;

  assign trigger   = (state == ST_IDLE) && (bus.x == TRIGGER_X);
  assign next_line = (bus.y == LAST_LINE) ? 11'd0 : ({1'b0, bus.y} + 11'd1);

  // Read data lags the address by a cycle, so entry k-1 is judged while k is issued.
  assign eval_now  = ((state == ST_SCAN) && (addr != '0)) || (state == ST_DRAIN);
  assign entry_hit = entry_enable(bus.oam_rdata) &&
                     span_hit(next_line, entry_pos_y(bus.oam_rdata), TILE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          addr <= '0;
          if (trigger) state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (addr == LAST_ADDR) begin
            state <= ST_DRAIN;
            addr  <= '0;
          end else begin
            addr <= addr + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          state <= ST_SWAP;
          addr  <= '0;
        end
        ST_SWAP: begin
          state <= ST_IDLE;
          addr  <= '0;
        end
        default: begin
          state <= ST_IDLE;
          addr  <= '0;
        end
      endcase
    end
  end

  // Pending set is built up during the scan and only becomes visible at SWAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_count <= '0;
      pend_ovf   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) pend_slots[i] <= '0;
    end else if (trigger) begin
      pend_count <= '0;
      pend_ovf   <= 1'b0;
    end else if (eval_now && entry_hit) begin
      if (pend_count < SLOT_MAX) begin
        pend_slots[IW'(pend_count)] <= bus.oam_rdata;
        pend_count                  <= pend_count + COUNT_ONE;
      end else begin
        pend_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_count <= '0;
      act_ovf   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) act_slots[i] <= '0;
    end else if (state == ST_SWAP) begin
      act_count <= pend_count;
      act_ovf   <= pend_ovf;
      for (int i = 0; i < SLOTS; i++) act_slots[i] <= pend_slots[i];
    end
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) act_x[i] = entry_pos_x(act_slots[i]);
  end

  oam_slot_select #(
    .SLOTS (SLOTS),
    .TILE  (TILE)
  ) u_select (
    .slot_x     (act_x),
    .slot_count (act_count),
    .px         (bus.x),
    .sel_idx    (sel_idx),
    .sel_hit    (sel_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_valid_q <= 1'b0;
      obj_data_q  <= '0;
    end else if (bus.video_on && sel_hit) begin
      obj_valid_q <= 1'b1;
      obj_data_q  <= act_slots[sel_idx];
    end else begin
      obj_valid_q <= 1'b0;
      obj_data_q  <= '0;
    end
  end

  assign bus.oam_addr  = addr;
  assign bus.obj_data  = obj_data_q;
  assign bus.obj_valid = obj_valid_q;
  assign bus.overflow  = act_ovf;
  assign bus.scan_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_oam_line_scheduler.sv
// Directed bench for oam_line_scheduler with a one-cycle-latency OAM model.
module tb_oam_line_scheduler;

  localparam int OAM_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem [OAM_DEPTH];

  oam_line_scheduler_if #(.OAM_DEPTH(OAM_DEPTH)) bus ();

  oam_line_scheduler #(
    .OAM_DEPTH    (OAM_DEPTH),
    .SLOTS        (4),
    .TILE         (32),
    .H_SCAN_START (640),
    .V_LINES      (525)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.oam_rdata <= mem[bus.oam_addr];

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic en, input int px, input int py,
                                     input logic [7:0] low);
    return {1'b0, 2'b01, en, 10'(px), 10'(py), low};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int xv, input int yv, input logic von);
    bus.x        = 10'(xv);
    bus.y        = 10'(yv);
    bus.video_on = von;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expectPixel(input string tag, input int xv, input int yv,
                             input logic [31:0] exp_data);
    applyStimulus(xv, yv, 1'b1);
    checkOutput({tag, "_valid"}, {31'd0, bus.obj_valid}, {31'd0, exp_data != 32'd0});
    checkOutput({tag, "_data"}, bus.obj_data, exp_data);
  endtask

  // Trigger a scan from line yv and measure cycles until the scan FSM is idle again.
  task automatic runScan(input int yv, input string tag);
    int          n;
    logic [31:0] addr3;
    n     = 0;
    addr3 = 32'hFFFF_FFFF;
    applyStimulus(640, yv, 1'b1);
    checkOutput({tag, "_busy_start"}, {31'd0, bus.scan_busy}, 32'd1);
    while (bus.scan_busy && n < 40) begin
      n++;
      applyStimulus(640 + n, yv, 1'b1);
      if (n == 3) addr3 = 32'(bus.oam_addr);
    end
    checkOutput({tag, "_latency"}, n, 32'd10);
    checkOutput({tag, "_addr3"}, addr3, 32'd3);
    checkOutput({tag, "_addr_idle"}, 32'(bus.oam_addr), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.x        = '0;
    bus.y        = '0;
    bus.video_on = 1'b0;
    for (int i = 0; i < OAM_DEPTH; i++) mem[i] = '0;

    #1;
    checkOutput("rst_valid", {31'd0, bus.obj_valid}, 32'd0);
    checkOutput("rst_data", bus.obj_data, 32'd0);
    checkOutput("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.scan_busy}, 32'd0);
    checkOutput("rst_addr", 32'(bus.oam_addr), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    applyStimulus(0, 0, 1'b0);

    // Single object, span edges
    mem[0] = mk(1'b1, 100, 50, 8'h5A);
    runScan(49, "a");
    expectPixel("a_x99", 99, 50, 32'd0);
    expectPixel("a_x100", 100, 50, mem[0]);
    expectPixel("a_x131", 131, 50, mem[0]);
    expectPixel("a_x132", 132, 50, 32'd0);
    applyStimulus(110, 50, 1'b0);
    checkOutput("a_video_off", {31'd0, bus.obj_valid}, 32'd0);
    checkOutput("a_ovf", {31'd0, bus.overflow}, 32'd0);

    // Six hits on one line, only four slots
    for (int i = 0; i < 6; i++) mem[i] = mk(1'b1, i * 40, 200, 8'(i));
    runScan(199, "b");
    checkOutput("b_ovf", {31'd0, bus.overflow}, 32'd1);
    expectPixel("b_e0", 5, 200, mem[0]);
    expectPixel("b_e3", 125, 200, mem[3]);
    expectPixel("b_e4_dropped", 165, 200, 32'd0);
    for (int i = 2; i < 6; i++) mem[i] = mk(1'b0, i * 40, 200, 8'(i));
    runScan(200, "b2");
    checkOutput("b2_ovf", {31'd0, bus.overflow}, 32'd0);
    expectPixel("b2_e1", 45, 201, mem[1]);
    expectPixel("b2_e3_gone", 125, 201, 32'd0);

    // Overlap priority, disabled entries ignored
    for (int i = 0; i < OAM_DEPTH; i++) mem[i] = mk(1'b0, 310, 300, 8'(8'hC0 + i));
    mem[1] = mk(1'b1, 300, 300, 8'h11);
    mem[3] = mk(1'b1, 310, 300, 8'h33);
    runScan(299, "c");
    checkOutput("c_ovf", {31'd0, bus.overflow}, 32'd0);
    expectPixel("c_x310", 310, 300, mem[1]);
    expectPixel("c_x320", 320, 300, mem[1]);
    expectPixel("c_x335", 335, 300, mem[3]);
    expectPixel("c_x342", 342, 300, 32'd0);

    // Frame wrap and high positions without arithmetic wrap
    for (int i = 0; i < OAM_DEPTH; i++) mem[i] = '0;
    mem[0] = mk(1'b1, 50, 0, 8'hD0);
    runScan(524, "d");
    expectPixel("d_wrap", 60, 0, mem[0]);
    mem[0] = mk(1'b1, 500, 1000, 8'hD1);
    runScan(1010, "d2");
    expectPixel("d2_high", 510, 1011, mem[0]);

    // Reset in the middle of a scan
    for (int i = 0; i < 6; i++) mem[i] = mk(1'b1, i * 40, 200, 8'(i));
    runScan(199, "e0");
    checkOutput("e0_ovf", {31'd0, bus.overflow}, 32'd1);
    applyStimulus(640, 199, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(640 + i, 199, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("e_rst_busy", {31'd0, bus.scan_busy}, 32'd0);
    checkOutput("e_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    checkOutput("e_rst_valid", {31'd0, bus.obj_valid}, 32'd0);
    checkOutput("e_rst_data", bus.obj_data, 32'd0);
    checkOutput("e_rst_addr", 32'(bus.oam_addr), 32'd0);
    applyStimulus(100, 199, 1'b1);
    applyStimulus(101, 199, 1'b1);
    rst = 1'b0;
    expectPixel("e_after_rst", 5, 200, 32'd0);
    checkOutput("e_after_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    runScan(199, "e2");
    checkOutput("e2_ovf", {31'd0, bus.overflow}, 32'd1);
    expectPixel("e2_e0", 5, 200, mem[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
